lcd_fb_scanout: RTL and testbench

//  Reads the 128x64 monochrome frame buffer (1024 bytes: addr = page*128 + column, bit n = row page*8+n)
//  and streams it continuously to the LCD panel over a write-only 4-wire SPI link (SCLK/MOSI/DC/CS_n).

---
 rtl/lcd_pkg.sv | 49 ++++
 rtl/lcd_fb_scanout_if.sv | 30 +++
 rtl/lcd_spi_byte_tx.sv | 84 ++++++++
 rtl/lcd_fb_scanout.sv | 191 +++++++++++++++++++
 tb/tb_lcd_fb_scanout.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_pkg.sv
// ============================================================================
// Module : lcd_pkg
// Brief  : Shared constants, controller command bytes and FSM states for the
//          frame-buffer scan-out path. Macro: LCD_INIT_EN adds the INIT state.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package lcd_pkg;

    localparam int LCD_COLS  = 128;
    localparam int LCD_PAGES = 8;
    localparam int INIT_LEN  = 8;

    localparam logic [7:0] CMD_PAGE_BASE = 8'hB0;
    localparam logic [7:0] CMD_COL_HI    = 8'h10;
    localparam logic [7:0] CMD_COL_LO    = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
`ifdef LCD_INIT_EN
        ST_INIT      = 3'd1,
`endif
        ST_PAGE_CMD  = 3'd2,
        ST_FETCH     = 3'd3,
        ST_SEND      = 3'd4,
        ST_FRAME_END = 3'd5,
        ST_GAP       = 3'd6
    } lcd_state_t;

    // Controller power-up list, sent once after reset when enabled.
    function automatic logic [7:0] init_cmd(input logic [2:0] idx);
        logic [7:0] v;
        case (idx)
            3'd0:    v = 8'hE2;
            3'd1:    v = 8'hA2;
            3'd2:    v = 8'hA0;
            3'd3:    v = 8'hC8;
            3'd4:    v = 8'h2F;
            3'd5:    v = 8'h81;
            3'd6:    v = 8'h20;
            default: v = 8'hAF;
        endcase
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lcd_fb_scanout_if.sv
// ============================================================================
// Module : lcd_fb_scanout_if
// Brief  : Frame-buffer read port and 4-wire LCD SPI link of the scan-out block.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface lcd_fb_scanout_if;
    logic       enable;
    logic [9:0] ram_read_addr;
    logic [7:0] ram_read_data;
    logic       lcd_sclk;
    logic       lcd_mosi;
    logic       lcd_dc;
    logic       lcd_cs_n;
    logic       busy;
    logic       frame_done;

    modport master (
        input  enable, ram_read_data,
        output ram_read_addr, lcd_sclk, lcd_mosi, lcd_dc, lcd_cs_n, busy, frame_done
    );

    modport slave (
        output enable, ram_read_data,
        input  ram_read_addr, lcd_sclk, lcd_mosi, lcd_dc, lcd_cs_n, busy, frame_done
    );
endinterface

`default_nettype wire

// File: rtl/lcd_spi_byte_tx.sv
// ============================================================================
// Module : lcd_spi_byte_tx
// Brief  : Mode-0 SPI byte shifter, MSB first; SCLK half-period = CLK_DIV clk.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module lcd_spi_byte_tx #(
    parameter int CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  logic [7:0] i_data,
    input  logic       i_dc,
    output logic       o_sclk,
    output logic       o_mosi,
    output logic       o_dc,
    output logic       o_done
);

    localparam int                  c_div_w    = $clog2(CLK_DIV) + 1;
    localparam logic [c_div_w-1:0]  c_div_last = c_div_w'(CLK_DIV - 1);

    logic               r_active;
    logic [c_div_w-1:0] r_div;
    logic [2:0]         r_bit;
    logic [6:0]         r_shift;
    logic               r_sclk;
    logic               r_mosi;
    logic               r_dc;
    logic               r_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_active <= 1'b0;
            r_div    <= '0;
            r_bit    <= 3'd0;
            r_shift  <= 7'd0;
            r_sclk   <= 1'b0;
            r_mosi   <= 1'b0;
            r_dc     <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (!r_active) begin
                if (i_start) begin
                    r_active <= 1'b1;
                    r_shift  <= i_data[6:0];
                    r_mosi   <= i_data[7];
                    r_dc     <= i_dc;
                    r_bit    <= 3'd0;
                    r_div    <= '0;
                end
            end else if (r_div == c_div_last) begin
                r_div <= '0;
                if (!r_sclk) begin
                    r_sclk <= 1'b1;
                end else begin
                    // Falling edge: present the next bit, or finish the byte.
                    r_sclk <= 1'b0;
                    if (r_bit == 3'd7) begin
                        r_active <= 1'b0;
                        r_done   <= 1'b1;
                    end else begin
                        r_bit   <= r_bit + 3'd1;
                        r_mosi  <= r_shift[6];
                        r_shift <= {r_shift[5:0], 1'b0};
                    end
                end
            end else begin
                r_div <= r_div + 1'b1;
            end
        end
    end

    assign o_sclk = r_sclk;
    assign o_mosi = r_mosi;
    assign o_dc   = r_dc;
    assign o_done = r_done;

endmodule

`default_nettype wire

// File: rtl/lcd_fb_scanout.sv
// ============================================================================
// Module : lcd_fb_scanout
// Brief  : Streams the 128x64 frame buffer page by page to the LCD over SPI.
//          Macro: LCD_INIT_EN sends the controller init list once after reset.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module lcd_fb_scanout
    import lcd_pkg::*;
#(
    parameter int CLK_DIV     = 2,
    parameter int RAM_LATENCY = 2,
    parameter int FRAME_GAP   = 16
) (
    input  logic               clk,
    input  logic               rst,
    lcd_fb_scanout_if.master   bus
);

    localparam int                 c_gap_w    = $clog2(FRAME_GAP + 1);
    localparam logic [c_gap_w-1:0] c_gap_last = c_gap_w'(FRAME_GAP - 1);
    localparam logic [2:0]         c_lat      = 3'(RAM_LATENCY);

    lcd_state_t         r_state;
    logic [2:0]         r_page;
    logic [6:0]         r_col;
    logic [2:0]         r_idx;
    logic [2:0]         r_lat;
    logic [c_gap_w-1:0] r_gap;
    logic               r_wait;
    logic               r_tx_start;
    logic [7:0]         r_tx_byte;
    logic               r_tx_dc;
    logic [9:0]         r_addr;
    logic               r_cs_n;
    logic               r_busy;
    logic               r_frame_done;
`ifdef LCD_INIT_EN
    logic               r_init_done;
`endif
    logic               w_tx_done;
    logic [7:0]         w_cmd_byte;

    always_comb begin
        w_cmd_byte = CMD_COL_LO;
        case (r_idx)
            3'd0:    w_cmd_byte = CMD_PAGE_BASE | {5'd0, r_page};
            3'd1:    w_cmd_byte = CMD_COL_HI;
            default: w_cmd_byte = CMD_COL_LO;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_page       <= 3'd0;
            r_col        <= 7'd0;
            r_idx        <= 3'd0;
            r_lat        <= 3'd0;
            r_gap        <= '0;
            r_wait       <= 1'b0;
            r_tx_start   <= 1'b0;
            r_tx_byte    <= 8'd0;
            r_tx_dc      <= 1'b0;
            r_addr       <= 10'd0;
            r_cs_n       <= 1'b1;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
`ifdef LCD_INIT_EN
            r_init_done  <= 1'b0;
`endif
        end else begin
            r_tx_start   <= 1'b0;
            r_frame_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.enable) begin
                        r_cs_n <= 1'b0;
                        r_busy <= 1'b1;
                        r_page <= 3'd0;
                        r_col  <= 7'd0;
                        r_idx  <= 3'd0;
                        r_wait <= 1'b0;
`ifdef LCD_INIT_EN
                        r_state <= r_init_done ? ST_PAGE_CMD : ST_INIT;
`else
                        r_state <= ST_PAGE_CMD;
`endif
                    end
                end
`ifdef LCD_INIT_EN
                ST_INIT: begin
                    if (!r_wait) begin
                        r_tx_start <= 1'b1;
                        r_tx_byte  <= init_cmd(r_idx);
                        r_tx_dc    <= 1'b0;
                        r_wait     <= 1'b1;
                    end else if (w_tx_done) begin
                        r_wait <= 1'b0;
                        r_idx  <= r_idx + 3'd1;
                        if (r_idx == 3'(INIT_LEN - 1)) begin
                            r_init_done <= 1'b1;
                            r_state     <= ST_PAGE_CMD;
                        end
                    end
                end
`endif
                ST_PAGE_CMD: begin
                    if (!r_wait) begin
                        r_tx_start <= 1'b1;
                        r_tx_byte  <= w_cmd_byte;
                        r_tx_dc    <= 1'b0;
                        r_wait     <= 1'b1;
                    end else if (w_tx_done) begin
                        r_wait <= 1'b0;
                        if (r_idx == 3'd2) begin
                            r_idx   <= 3'd0;
                            r_addr  <= {r_page, r_col};
                            r_lat   <= 3'd0;
                            r_state <= ST_FETCH;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end
                end
                ST_FETCH: begin
                    // Address has been stable RAM_LATENCY cycles: data is valid now.
                    if (r_lat == c_lat) begin
                        r_tx_start <= 1'b1;
                        r_tx_byte  <= bus.ram_read_data;
                        r_tx_dc    <= 1'b1;
                        r_state    <= ST_SEND;
                    end else begin
                        r_lat <= r_lat + 3'd1;
                    end
                end
                ST_SEND: begin
                    if (w_tx_done) begin
                        r_col <= r_col + 7'd1;
                        if (r_col == 7'(LCD_COLS - 1)) begin
                            r_page  <= r_page + 3'd1;
                            r_state <= (r_page == 3'(LCD_PAGES - 1)) ? ST_FRAME_END : ST_PAGE_CMD;
                        end else begin
                            r_addr  <= {r_page, r_col + 7'd1};
                            r_lat   <= 3'd0;
                            r_state <= ST_FETCH;
                        end
                    end
                end
                ST_FRAME_END: begin
                    r_frame_done <= 1'b1;
                    r_cs_n       <= 1'b1;
                    r_gap        <= '0;
                    r_state      <= ST_GAP;
                end
                ST_GAP: begin
                    if (r_gap == c_gap_last) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    lcd_spi_byte_tx #(
        .CLK_DIV (CLK_DIV)
    ) u_tx (
        .clk     (clk),
        .rst     (rst),
        .i_start (r_tx_start),
        .i_data  (r_tx_byte),
        .i_dc    (r_tx_dc),
        .o_sclk  (bus.lcd_sclk),
        .o_mosi  (bus.lcd_mosi),
        .o_dc    (bus.lcd_dc),
        .o_done  (w_tx_done)
    );

    assign bus.ram_read_addr = r_addr;
    assign bus.lcd_cs_n      = r_cs_n;
    assign bus.busy          = r_busy;
    assign bus.frame_done    = r_frame_done;

endmodule

`default_nettype wire

// File: tb/tb_lcd_fb_scanout.sv
// ============================================================================
// Module : tb_lcd_fb_scanout
// Brief  : Self-checking bench: SPI decoder compared against a frame-level
//          byte-stream model. Macro: LCD_INIT_EN expects the init list.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_lcd_fb_scanout;

    localparam int CLK_DIV     = 1;
    localparam int RAM_LATENCY = 2;
    localparam int FRAME_GAP   = 16;
    localparam int FRAME_BYTES = 8 * (3 + 128);
`ifdef LCD_INIT_EN
    localparam int INIT_N = 8;
    localparam logic [7:0] INIT_LIST [0:7] = '{8'hE2, 8'hA2, 8'hA0, 8'hC8, 8'h2F, 8'h81, 8'h20, 8'hAF};
`else
    localparam int INIT_N = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lcd_fb_scanout_if bus ();

    lcd_fb_scanout #(
        .CLK_DIV     (CLK_DIV),
        .RAM_LATENCY (RAM_LATENCY),
        .FRAME_GAP   (FRAME_GAP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    // Frame-buffer RAM with a RAM_LATENCY-deep read pipeline
    logic [7:0] mem     [0:1023];
    logic [7:0] rd_pipe [0:RAM_LATENCY-1];
    always @(posedge clk) begin
        rd_pipe[0] <= mem[bus.ram_read_addr];
        for (int i = 1; i < RAM_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bus.ram_read_data = rd_pipe[RAM_LATENCY-1];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor / model state
    logic [8:0] exp_q [$];
    logic [8:0] rx_log [0:1199];
    logic [8:0] frame_first [0:3];
    logic [8:0] got;
    logic [8:0] exp_b;
    logic [7:0] shreg;
    logic       byte_dc;
    logic       prev_sclk, prev_mosi, prev_cs;
    bit         init_pending;
    int rx_total, frame_bytes, frames_started, fd_count, cs_hi_cnt, bitcnt, hi_len, since_rise;

    // Expected byte stream of one whole frame, from the current RAM contents
    task automatic push_frame();
`ifdef LCD_INIT_EN
        if (init_pending) for (int i = 0; i < 8; i++) exp_q.push_back({1'b0, INIT_LIST[i]});
`endif
        init_pending = 1'b0;
        for (int p = 0; p < 8; p++) begin
            exp_q.push_back({1'b0, 8'hB0 | 8'(p)});
            exp_q.push_back(9'h010);
            exp_q.push_back(9'h000);
            for (int c = 0; c < 128; c++) exp_q.push_back({1'b1, mem[p*128 + c]});
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            rx_total = 0; frame_bytes = 0; frames_started = 0; fd_count = 0;
            cs_hi_cnt = 0; bitcnt = 0; hi_len = 0; since_rise = 0;
            init_pending = 1'b1;
            prev_sclk = 1'b0; prev_mosi = 1'b0; prev_cs = 1'b1;
        end else begin
            if (prev_cs && !bus.lcd_cs_n) begin
                chk("queue_empty_at_frame_start", exp_q.size(), 0);
                if (frames_started > 0) begin
                    chk("cs_gap_min", 32'(cs_hi_cnt >= FRAME_GAP), 1);
                    chk("frame_done_pulses", fd_count, 1);
                end
                frames_started++;
                frame_bytes = 0;
                fd_count    = 0;
                push_frame();
            end
            if (bus.lcd_cs_n) cs_hi_cnt++; else cs_hi_cnt = 0;
            if (!prev_cs && bus.lcd_cs_n) chk("queue_empty_at_cs_rise", exp_q.size(), 0);
            if (bus.frame_done) begin
                fd_count++;
                chk("bytes_at_frame_done", frame_bytes, FRAME_BYTES + ((frames_started == 1) ? INIT_N : 0));
            end
            if (bus.lcd_cs_n) chk("sclk_idle_deselected", bus.lcd_sclk, 0);
            else              chk("busy_during_frame", bus.busy, 1);
            if (prev_sclk && bus.lcd_sclk) chk("mosi_stable_high", bus.lcd_mosi, prev_mosi);
            if (bus.lcd_sclk) hi_len++;
            if (prev_sclk && !bus.lcd_sclk) begin
                chk("sclk_high_len", hi_len, CLK_DIV);
                hi_len = 0;
            end
            since_rise++;
            if (!prev_sclk && bus.lcd_sclk) begin
                if (bitcnt > 0) begin
                    chk("bit_period", since_rise, 2 * CLK_DIV);
                    chk("dc_stable", bus.lcd_dc, byte_dc);
                end else begin
                    byte_dc = bus.lcd_dc;
                end
                since_rise = 0;
                shreg = {shreg[6:0], bus.lcd_mosi};
                bitcnt++;
                if (bitcnt == 8) begin
                    bitcnt = 0;
                    got = {byte_dc, shreg};
                    if (rx_total < 1200) rx_log[rx_total] = got;
                    rx_total++;
                    frame_bytes++;
                    if (frame_bytes == 1 && frames_started >= 1 && frames_started <= 4)
                        frame_first[frames_started-1] = got;
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL extra_byte: got %0h expected none", got);
                    end else begin
                        exp_b = exp_q.pop_front();
                        chk("stream_byte", got, exp_b);
                    end
                end
            end
            prev_sclk = bus.lcd_sclk;
            prev_mosi = bus.lcd_mosi;
            prev_cs   = bus.lcd_cs_n;
        end
    end

    initial begin
        int n;
        int k;
        int base;
        for (int i = 0; i < 1024; i++) mem[i] = 8'(i) ^ 8'hA5;
        bus.enable = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_addr", bus.ram_read_addr, 0);
        chk("rst_sclk", bus.lcd_sclk, 0);
        chk("rst_mosi", bus.lcd_mosi, 0);
        chk("rst_dc", bus.lcd_dc, 0);
        chk("rst_cs_n", bus.lcd_cs_n, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_frame_done", bus.frame_done, 0);
        #1 rst = 1'b0;
        @(negedge clk);
        #1 bus.enable = 1'b1;

        // Frame 1: pinned pattern addr^A5
        n = 0;
        while (!bus.frame_done && n < 40000) begin @(negedge clk); #1; n++; end
        chk("frame1_timeout", 32'(n < 40000), 1);
        base = INIT_N;
`ifdef LCD_INIT_EN
        for (int i = 0; i < 8; i++) chk("init_byte", rx_log[i], {1'b0, INIT_LIST[i]});
`endif
        chk("p0_cmd0", rx_log[base+0], 9'h0B0);
        chk("p0_cmd1", rx_log[base+1], 9'h010);
        chk("p0_cmd2", rx_log[base+2], 9'h000);
        chk("p0_data0", rx_log[base+3], 9'h1A5);
        chk("p0_data1", rx_log[base+4], 9'h1A4);
        chk("p0_data2", rx_log[base+5], 9'h1A7);
        chk("p1_cmd0", rx_log[base+131], 9'h0B1);
        chk("p1_cmd1", rx_log[base+132], 9'h010);
        chk("p1_cmd2", rx_log[base+133], 9'h000);
        chk("p1_data0", rx_log[base+134], 9'h125);
        chk("frame1_bytes", frame_bytes, 1048 + INIT_N);

        // Frame 2: random RAM contents, enable dropped at byte 200
        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
        n = 0;
        while (!(frames_started == 2 && frame_bytes >= 200) && n < 30000) begin @(negedge clk); #1; n++; end
        chk("frame2_start_timeout", 32'(n < 30000), 1);
        bus.enable = 1'b0;
        n = 0;
        while (!bus.frame_done && n < 40000) begin @(negedge clk); #1; n++; end
        chk("frame2_done_timeout", 32'(n < 40000), 1);
        chk("frame2_bytes", frame_bytes, 1048);
        chk("frame2_first_byte", frame_first[1], 9'h0B0);
        n = 0;
        while (bus.busy && n < 100) begin @(negedge clk); #1; n++; end
        chk("busy_fall_timeout", 32'(n < 100), 1);
        chk("idle_cs_n", bus.lcd_cs_n, 1);
        chk("gap_before_idle", 32'(cs_hi_cnt >= FRAME_GAP), 1);
        chk("frame2_done_pulses", fd_count, 1);
        repeat (300) @(negedge clk);
        #1;
        chk("no_new_frame", frames_started, 2);
        chk("stays_idle_busy", bus.busy, 0);
        chk("stays_idle_cs_n", bus.lcd_cs_n, 1);

        // Frame 3: asynchronous reset in the middle of a data byte
        k = $urandom_range(3, 20);
        bus.enable = 1'b1;
        n = 0;
        while (!(frames_started == 3 && frame_bytes >= k && bitcnt == 3) && n < 30000) begin
            @(negedge clk); #1; n++;
        end
        chk("frame3_timeout", 32'(n < 30000), 1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_sclk", bus.lcd_sclk, 0);
        chk("async_rst_cs_n", bus.lcd_cs_n, 1);
        chk("async_rst_dc", bus.lcd_dc, 0);
        chk("async_rst_busy", bus.busy, 0);
        chk("async_rst_addr", bus.ram_read_addr, 0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        n = 0;
        while (rx_total < 12 && n < 3000) begin @(negedge clk); #1; n++; end
        chk("post_reset_timeout", 32'(n < 3000), 1);
`ifdef LCD_INIT_EN
        chk("post_reset_first", rx_log[0], 9'h0E2);
        chk("post_reset_page", rx_log[8], 9'h0B0);
`else
        chk("post_reset_first", rx_log[0], 9'h0B0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
